// File: rtl/scan_host_bridge.sv
// Host-side driver for the TinyTapeout scan chain: one command frame is shifted in and
// one captured frame is returned per CAPTURE / SHIFT / LATCH sequence.
module scan_host_bridge #(
    parameter int SCAN_LENGTH = 96,
    parameter int CLK_DIV     = 1
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [SCAN_LENGTH-1:0] i_cmd_data,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [SCAN_LENGTH-1:0] o_rsp_data,
    output logic                   o_scan_clk,
    output logic                   o_scan_data,
    output logic                   o_scan_select,
    output logic                   o_latch_enable,
    input  logic                   i_scan_data,
    output logic                   o_busy
);
    localparam int PERIOD = 2 * CLK_DIV;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BW     = $clog2(SCAN_LENGTH + 1);

    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SCAN_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SHIFT   = 3'd2,
        S_LATCH   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [SCAN_LENGTH-1:0] tx_q, tx_d;
    logic [SCAN_LENGTH-1:0] rx_q, rx_d;
    logic [SCAN_LENGTH-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   scan_clk_q, scan_clk_d;
    logic                   scan_data_q, scan_data_d;
    logic                   scan_sel_q, scan_sel_d;
    logic                   latch_q, latch_d;
    logic                   period_end;
    logic [PW-1:0]          phase_inc;

    assign period_end = (phase_q == PH_LAST);
    assign phase_inc  = period_end ? '0 : phase_q + PW'(1);

    // Pin registers follow the state one cycle later, so every pin is a clean flop output.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        scan_clk_d  = 1'b0;
        scan_data_d = 1'b0;
        scan_sel_d  = 1'b0;
        latch_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    tx_d    = i_cmd_data;
                    rx_d    = '0;
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                scan_sel_d = 1'b1;
                scan_clk_d = (phase_q >= PH_HALF);
                phase_d    = phase_inc;
                if (period_end) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scan_clk_d  = (phase_q >= PH_HALF);
                scan_data_d = (phase_q == '0) ? tx_q[SCAN_LENGTH-1] : scan_data_q;
                // Sample on the same fabric edge that raises the scan clock.
                if (phase_q == PH_HALF) begin
                    rx_d = {rx_q[SCAN_LENGTH-2:0], i_scan_data};
                    tx_d = {tx_q[SCAN_LENGTH-2:0], 1'b0};
                end
                phase_d = phase_inc;
                if (period_end) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                latch_d = (phase_q < PH_HALF);
                phase_d = phase_inc;
                if (period_end) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end else if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            scan_clk_q  <= 1'b0;
            scan_data_q <= 1'b0;
            scan_sel_q  <= 1'b0;
            latch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            scan_clk_q  <= scan_clk_d;
            scan_data_q <= scan_data_d;
            scan_sel_q  <= scan_sel_d;
            latch_q     <= latch_d;
        end
    end

    assign o_cmd_ready    = cmd_ready_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_scan_clk     = scan_clk_q;
    assign o_scan_data    = scan_data_q;
    assign o_scan_select  = scan_sel_q;
    assign o_latch_enable = latch_q;
    assign o_busy         = busy_q;

endmodule
